// File: rtl/ddot_result_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddot_result_fifo : tagged result FIFO for the 4-wide FP dot-product datapath.
// Optional: DDOT_RFIFO_OVF_CNT_EN adds the 16-bit saturating ovf_cnt port.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ddot_result_fifo #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic [31:0]              in_z,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_z,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
`ifdef DDOT_RFIFO_OVF_CNT_EN
  ,output logic [15:0]             ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TAG_W + 32;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d;
`ifdef DDOT_RFIFO_OVF_CNT_EN
  logic [15:0]      ovf_cnt_q, ovf_cnt_d;
`endif

  logic w_full, w_empty, w_pop, w_push, w_drop;

  assign w_full  = (cnt_q == CW'(DEPTH));
  assign w_empty = (cnt_q == '0);
  assign w_pop   = !w_empty && out_ready;
  // A pop frees the head slot in the same edge, so a full FIFO can still accept.
  assign w_push  = in_vld && (!w_full || w_pop);
  assign w_drop  = in_vld && w_full && !w_pop;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    seq_d  = seq_q;
    ovf_d  = ovf_q;
`ifdef DDOT_RFIFO_OVF_CNT_EN
    ovf_cnt_d = ovf_cnt_q;
`endif
    if (in_vld) seq_d = seq_q + TAG_W'(1);
    if (w_push) wptr_d = wptr_q + AW'(1);
    if (w_pop)  rptr_d = rptr_q + AW'(1);
    if (w_push && !w_pop)      cnt_d = cnt_q + CW'(1);
    else if (w_pop && !w_push) cnt_d = cnt_q - CW'(1);
    if (w_drop) begin
      ovf_d = 1'b1;
`ifdef DDOT_RFIFO_OVF_CNT_EN
      if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
`ifdef DDOT_RFIFO_OVF_CNT_EN
      ovf_cnt_q <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
`ifdef DDOT_RFIFO_OVF_CNT_EN
      ovf_cnt_q <= '0;
`endif
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
`ifdef DDOT_RFIFO_OVF_CNT_EN
      ovf_cnt_q <= ovf_cnt_d;
`endif
      if (w_push) mem_q[wptr_q] <= {seq_q, in_z};
    end
  end

  assign out_valid = !w_empty;
  assign out_z     = mem_q[rptr_q][31:0];
  assign out_tag   = mem_q[rptr_q][EW-1:32];
  assign fifo_cnt  = cnt_q;
  assign full      = w_full;
  assign empty     = w_empty;
  assign ovf       = ovf_q;
`ifdef DDOT_RFIFO_OVF_CNT_EN
  assign ovf_cnt   = ovf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddot_result_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ddot_result_fifo : randomized + directed bench against a queue model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ddot_result_fifo;

  localparam int DEPTH = 8;
  localparam int TAG_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_vld = 1'b0;
  logic [31:0]      in_z = '0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [31:0]      out_z;
  logic [TAG_W-1:0] out_tag;
  logic [CW-1:0]    fifo_cnt;
  logic             full, empty, ovf;
`ifdef DDOT_RFIFO_OVF_CNT_EN
  logic [15:0]      ovf_cnt;
`endif

  ddot_result_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_z(in_z), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_z(out_z),
    .out_tag(out_tag), .fifo_cnt(fifo_cnt), .full(full), .empty(empty),
    .ovf(ovf)
`ifdef DDOT_RFIFO_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: queue of {tag, z}, free-running tag, drop bookkeeping.
  logic [TAG_W+31:0] mq[$];
  int unsigned       m_seq = 0;
  logic              m_ovf = 1'b0;
  int unsigned       m_ovf_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic f, input logic v,
                            input logic [31:0] z, input logic rdy);
    bit do_pop;
    if (r || f) begin
      mq.delete();
      m_seq = 0; m_ovf = 1'b0; m_ovf_cnt = 0;
    end else begin
      do_pop = (mq.size() > 0) && rdy;
      if (do_pop) void'(mq.pop_front());
      if (v) begin
        if (mq.size() < DEPTH) mq.push_back({m_seq[TAG_W-1:0], z});
        else begin
          m_ovf = 1'b1;
          if (m_ovf_cnt < 65535) m_ovf_cnt++;
        end
        m_seq = (m_seq + 1) % (1 << TAG_W);
      end
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("fifo_cnt",  64'(fifo_cnt),  64'(mq.size()));
    chk("full",      64'(full),      64'(mq.size() == DEPTH));
    chk("empty",     64'(empty),     64'(mq.size() == 0));
    chk("ovf",       64'(ovf),       64'(m_ovf));
`ifdef DDOT_RFIFO_OVF_CNT_EN
    chk("ovf_cnt",   64'(ovf_cnt),   64'(m_ovf_cnt));
`endif
    if (mq.size() > 0) begin
      chk("out_z",   64'(out_z),   64'(mq[0][31:0]));
      chk("out_tag", 64'(out_tag), 64'(mq[0][TAG_W+31:32]));
    end
  endtask

  // Drive one cycle from a negedge, advance the model, check at the next negedge.
  task automatic tick(input logic r, input logic f, input logic v,
                      input logic [31:0] z, input logic rdy);
    rst = r; flush = f; in_vld = v; in_z = z; out_ready = rdy;
    model_step(r, f, v, z, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_z",     64'(out_z),     64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    chk("rst_fifo_cnt",  64'(fifo_cnt),  64'd0);
    chk("rst_full",      64'(full),      64'd0);
    chk("rst_empty",     64'(empty),     64'd1);
    chk("rst_ovf",       64'(ovf),       64'd0);
`ifdef DDOT_RFIFO_OVF_CNT_EN
    chk("rst_ovf_cnt",   64'(ovf_cnt),   64'd0);
`endif
  endtask

  initial begin
    logic [31:0]      z3 [3];
    logic [TAG_W-1:0] drain_tags [8];
    logic [31:0]      hold_z;
    logic [TAG_W-1:0] hold_tag, prev_tag;
    bit               saw_wrap;

    z3[0] = 32'h3F80_0000; z3[1] = 32'h4000_0000; z3[2] = 32'h4040_0000;
    @(negedge clk);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check_reset_values();

    // Three pushes held, then popped in order.
    for (int i = 0; i < 3; i++) tick(0, 0, 1, z3[i], 0);
    chk("t1_cnt3", 64'(fifo_cnt), 64'd3);
    chk("t1_head_tag", 64'(out_tag), 64'd0);
    chk("t1_head_z", 64'(out_z), 64'h3F80_0000);
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop_tag", 64'(out_tag), 64'(i));
      tick(0, 0, 0, 0, 1);
    end
    chk("t1_empty", 64'(empty), 64'd1);

    // Overflow: 10 strobes into an 8-deep FIFO, then push+pop while full.
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 32'h1000 + 32'(i), 0);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_ovf", 64'(ovf), 64'd1);
    chk("t2_cnt", 64'(fifo_cnt), 64'd8);
`ifdef DDOT_RFIFO_OVF_CNT_EN
    chk("t2_ovf_cnt", 64'(ovf_cnt), 64'd2);
`endif
    tick(0, 0, 1, 32'hABCD_0010, 1);
    chk("t2_cnt_stays", 64'(fifo_cnt), 64'd8);
    for (int i = 0; i < 7; i++) drain_tags[i] = TAG_W'(i + 1);
    drain_tags[7] = TAG_W'(10);
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_tag", 64'(out_tag), 64'(drain_tags[i]));
      tick(0, 0, 0, 0, 1);
    end

    // Sustained push+pop across tag wrap.
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, $urandom, 0);
    saw_wrap = 0;
    prev_tag = out_tag;
    for (int i = 0; i < 300; i++) begin
      tick(0, 0, 1, $urandom, 1);
      chk("t3_cnt_const", 64'(fifo_cnt), 64'd4);
      if (prev_tag == 8'd255 && out_tag == 8'd0) saw_wrap = 1;
      prev_tag = out_tag;
    end
    chk("t3_tag_wrapped", 64'(saw_wrap), 64'd1);
    chk("t3_no_drop", 64'(ovf), 64'd0);

    // Flush colliding with a strobe.
    for (int i = 0; i < 1; i++) tick(0, 0, 0, 0, 1);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, $urandom, 0);
    tick(0, 1, 1, 32'hDEAD_BEEF, 0);
    chk("t4_empty", 64'(empty), 64'd1);
    chk("t4_ovf", 64'(ovf), 64'd0);
    tick(0, 0, 1, 32'h1234_5678, 0);
    chk("t4_tag0", 64'(out_tag), 64'd0);
    chk("t4_z", 64'(out_z), 64'h1234_5678);

    // Head stable while stalled, even with pushes arriving.
    hold_z = out_z; hold_tag = out_tag;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, i[0], $urandom, 0);
      chk("t5_hold_z", 64'(out_z), 64'(hold_z));
      chk("t5_hold_tag", 64'(out_tag), 64'(hold_tag));
    end

    // Reset mid-burst with overflow flagged.
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, $urandom, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1);
    chk("t6_cnt4", 64'(fifo_cnt), 64'd4);
    chk("t6_ovf", 64'(ovf), 64'd1);
    tick(1, 0, 1, 32'hFFFF_FFFF, 1);
    check_reset_values();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddot_result_fifo.md
# ddot_result_fifo

Output-side buffer for the 4-wide FP dot-product pipeline. It captures every `vld`/`z` result the dot-product datapath produces and tags it with a sequence number. Results are held in a small FIFO and handed to the consumer (host readback / writeback stage) over a valid/ready handshake. The datapath has no backpressure, so this block absorbs bursts and records any result it has to drop.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2 to 64.
- `TAG_W`, 8: width of the result sequence tag.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_vld`, input, 1: result strobe from the dot-product datapath.
- `in_z`, input, 32: IEEE-754 single result; sampled only when `in_vld`=1.
- `flush`, input, 1: synchronous clear of FIFO contents and status.
- `out_ready`, input, 1: consumer accepts the head entry.
- `out_valid`, output, 1: head entry present.
- `out_z`, output, 32: head result data.
- `out_tag`, output, TAG_W: sequence tag of the head entry.
- `fifo_cnt`, output, $clog2(DEPTH)+1: current occupancy.
- `full`, output, 1: `fifo_cnt`==DEPTH.
- `empty`, output, 1: `fifo_cnt`==0.
- `ovf`, output, 1: sticky; set when a result is dropped.
- `ovf_cnt`, output, 16: dropped-result count. Present only with `DDOT_RFIFO_OVF_CNT_EN`.

## Operation
- Storage is a circular buffer of DEPTH entries, each entry {tag, z}. It has a write pointer, a read pointer (log2 DEPTH bits, natural wrap) and a separate count register.
- Tag counter `seq` (TAG_W bits, wraps from 2^TAG_W−1 to 0) increments on every `in_vld`=1, whether the result is stored or dropped. Dropped results therefore appear as gaps in the `out_tag` sequence.
- Push: `in_vld`=1 and (count<DEPTH or pop this cycle). Writes {seq, in_z} at the write pointer, then advances the pointer.
- Pop: `out_valid`=1 and `out_ready`=1. Advances the read pointer.
- Drop: `in_vld`=1, count==DEPTH and no pop in the same cycle. Data is discarded, `ovf` is set to 1, and `ovf_cnt` increments (saturating at 0xFFFF).
- Count update: +1 on push only, −1 on pop only, unchanged on push+pop together.
- Outputs:
  - `out_valid` = !empty.
  - `out_z`/`out_tag` = entry at the read pointer, a combinational read of the register array.
  - `out_z`/`out_tag` must be held stable while `out_valid`=1 and `out_ready`=0.
- Flush:
  - Clears pointers, count, `seq`, `ovf` and `ovf_cnt`.
  - Has priority over push, pop and drop in the same cycle. An `in_vld` in a flush cycle is discarded and neither counted nor tagged.
- Reset (`rst`=1): same clears as flush, and takes priority over flush. Reset values: `out_valid`=0, `out_z`=0 (storage cleared), `out_tag`=0, `fifo_cnt`=0, `full`=0, `empty`=1, `ovf`=0, `ovf_cnt`=0.
- Reset asserted mid-burst discards all held entries. No partial state survives.

## Timing
- Write-to-read latency: 1 cycle. A push at edge N gives `out_valid`=1 after edge N; data is poppable in cycle N+1.
- No bypass. When empty, `in_vld` is never visible on `out_*` in the same cycle.
- Throughput: one push and one pop per cycle, sustained, with no bubble at full or empty.
- `full`, `empty`, `fifo_cnt` and `ovf` are registered-state derived. They reflect the edge just taken.
- Pointer wrap is seamless from DEPTH−1 to 0.

## Configuration
- `DDOT_RFIFO_OVF_CNT_EN` defined: the 16-bit saturating `ovf_cnt` register and its port exist.
- Not defined: the `ovf_cnt` port and register are removed. Only the sticky `ovf` flag reports drops. All other behaviour is identical.

## Test plan
- Reset, then 3 pushes (z=0x3F800000, 0x40000000, 0x40400000) with `out_ready`=0. Expect `fifo_cnt`=3 and head tag 0. Then set `out_ready`=1: pops return tags 0,1,2 in order, and `empty`=1 after the third pop.
- DEPTH=8: 10 back-to-back `in_vld` with `out_ready`=0. Expect `full`=1 after 8 pushes, `ovf`=1, `ovf_cnt`=2, and stored tags 0..7. Then push once more with `out_ready`=1 in the same cycle: accepted with tag 10, `fifo_cnt` stays 8.
- Continuous push+pop for 300 cycles, TAG_W=8. Expect `fifo_cnt` constant, `out_tag` wrapping 255→0, and no drops.
- Assert `flush` together with `in_vld`, with 5 entries held. Next cycle: `empty`=1, `ovf`=0, `seq`=0. The following push carries tag 0.
- Hold `out_ready`=0 for 4 cycles with the FIFO non-empty. Expect `out_z`/`out_tag` unchanged throughout.
- Assert `rst` mid-burst (4 entries held, `ovf`=1). Expect all outputs at their reset values on the next cycle.
